// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file writeback unit.
// The optional pending-load scoreboard is enabled with WB_SCOREBOARD_EN (see wb_unit).
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_ALU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_skid.sv
// One-entry valid/ready buffer for a single writeback source.
// It accepts a new entry whenever it is empty or its current entry is granted this cycle.
module wb_skid
    import wb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      valid_i,
    input  wb_entry_t entry_i,
    output logic      ready_o,
    input  logic      grant_i,
    output logic      full_o,
    output wb_entry_t entry_o
);

    logic accept;

    assign ready_o = !full_o || grant_i;
    assign accept  = valid_i && ready_o;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_o <= 1'b0;
        end else if (accept) begin
            full_o <= 1'b1;
        end else if (grant_i) begin
            full_o <= 1'b0;
        end
    end

    // NOTE: the payload has no reset; full_o qualifies it, so reset only needs to clear the flag.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            entry_o <= entry_i;
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Register-file writeback unit: skids ALU and LSU results, arbitrates round-robin, drives one write port.
// Define WB_SCOREBOARD_EN to build the pending-load scoreboard; otherwise sb_busy_o is tied to 0.
module wb_unit
    import wb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alu_valid_i,
    input  logic [REG_AW-1:0] alu_rd_i,
    input  logic [XLEN-1:0]   alu_data_i,
    output logic              alu_ready_o,
    input  logic              lsu_valid_i,
    input  logic [REG_AW-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    output logic              lsu_ready_o,
    input  logic              sb_set_i,
    input  logic [REG_AW-1:0] sb_rd_i,
    output logic [NREGS-1:0]  sb_busy_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_rd_o,
    output logic [XLEN-1:0]   rf_wd_o
);

    wb_entry_t alu_in, lsu_in, alu_entry, lsu_entry, win_entry;
    logic      alu_full, lsu_full, alu_grant, lsu_grant, any_grant, conflict;
    wb_src_e   rr_ptr;

    assign alu_in = '{rd: alu_rd_i, data: alu_data_i};
    assign lsu_in = '{rd: lsu_rd_i, data: lsu_data_i};

    wb_skid u_alu_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (alu_valid_i),
        .entry_i (alu_in),
        .ready_o (alu_ready_o),
        .grant_i (alu_grant),
        .full_o  (alu_full),
        .entry_o (alu_entry)
    );

    wb_skid u_lsu_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (lsu_valid_i),
        .entry_i (lsu_in),
        .ready_o (lsu_ready_o),
        .grant_i (lsu_grant),
        .full_o  (lsu_full),
        .entry_o (lsu_entry)
    );

    assign conflict = alu_full && lsu_full;

    // NOTE: default every output first so no path through this block leaves a latch behind.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (conflict) begin
            if (rr_ptr == SRC_LSU) lsu_grant = 1'b1;
            else                   alu_grant = 1'b1;
        end else begin
            alu_grant = alu_full;
            lsu_grant = lsu_full;
        end
    end

    assign any_grant = alu_grant || lsu_grant;
    assign win_entry = lsu_grant ? lsu_entry : alu_entry;

    // Pointer moves only on a conflict; x0 entries are dequeued without a write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr  <= SRC_LSU;
            rf_we_o <= 1'b0;
            rf_rd_o <= '0;
            rf_wd_o <= '0;
        end else begin
            if (conflict) begin
                rr_ptr <= (rr_ptr == SRC_LSU) ? SRC_ALU : SRC_LSU;
            end
            rf_we_o <= any_grant && (win_entry.rd != '0);
            if (any_grant && (win_entry.rd != '0)) begin
                rf_rd_o <= win_entry.rd;
                rf_wd_o <= win_entry.data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NREGS-1:0] sb_busy_q;

    // The set is applied after the clear so a same-edge set of the same index wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_busy_q <= '0;
        end else begin
            if (lsu_grant && (lsu_entry.rd != '0)) begin
                sb_busy_q[lsu_entry.rd] <= 1'b0;
            end
            if (sb_set_i && (sb_rd_i != '0)) begin
                sb_busy_q[sb_rd_i] <= 1'b1;
            end
        end
    end

    assign sb_busy_o = sb_busy_q;
`else
    logic unused_sb;

    assign unused_sb = ^{sb_set_i, sb_rd_i};
    assign sb_busy_o = '0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: a queue of expected writes is filled as results are driven and
// drained by a monitor on every rf_we_o pulse; scenario tasks add cycle-exact inline checks.
module tb_wb_unit;
    import wb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              alu_valid, lsu_valid, sb_set;
    logic [REG_AW-1:0] alu_rd, lsu_rd, sb_rd;
    logic [XLEN-1:0]   alu_data, lsu_data;
    logic              alu_ready, lsu_ready;
    logic [NREGS-1:0]  sb_busy;
    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wd;

    int        n_cmp = 0;
    int        n_mis = 0;
    wb_entry_t exp_q[$];
    wb_entry_t mon_e;
    logic      sb_clear_ok = 1'b0;
    logic [XLEN-1:0] last_wd;

    wb_unit dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .alu_valid_i (alu_valid),
        .alu_rd_i    (alu_rd),
        .alu_data_i  (alu_data),
        .alu_ready_o (alu_ready),
        .lsu_valid_i (lsu_valid),
        .lsu_rd_i    (lsu_rd),
        .lsu_data_i  (lsu_data),
        .lsu_ready_o (lsu_ready),
        .sb_set_i    (sb_set),
        .sb_rd_i     (sb_rd),
        .sb_busy_o   (sb_busy),
        .rf_we_o     (rf_we),
        .rf_rd_o     (rf_rd),
        .rf_wd_o     (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void push_exp(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Every write pulse must match the oldest expected entry; decode must never re-mark a busy rd
    // unless that rd is being cleared on the same edge.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL wr_unexpected: got write rd=%0d wd=%h, required no write", rf_rd, rf_wd);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_rd !== mon_e.rd || rf_wd !== mon_e.data) begin
                    n_mis++;
                    $display("FAIL wr_order: got rd=%0d wd=%h, required rd=%0d wd=%h",
                             rf_rd, rf_wd, mon_e.rd, mon_e.data);
                end
            end
        end
        if (rst_n && sb_set && sb_rd != '0) begin
            n_cmp++;
            if (sb_busy[sb_rd] && !sb_clear_ok) begin
                n_mis++;
                $display("FAIL sb_double_set: got load issued to busy rd=%0d, required idle rd", sb_rd);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        sb_set = 1'b0; sb_rd = '0;
        #12;
        n_cmp++; if ({rf_we, rf_rd, rf_wd} !== '0) begin n_mis++; $display("FAIL rst_wport: got we=%b rd=%0d wd=%h, required 0", rf_we, rf_rd, rf_wd); end
        n_cmp++; if (sb_busy !== '0) begin n_mis++; $display("FAIL rst_sb: got %h, required 0", sb_busy); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b1) begin n_mis++; $display("FAIL rst_alu_ready: got %b, required 1", alu_ready); end
        n_cmp++; if (lsu_ready !== 1'b1) begin n_mis++; $display("FAIL rst_lsu_ready: got %b, required 1", lsu_ready); end
        n_cmp++; if (rf_we !== 1'b0) begin n_mis++; $display("FAIL rst_we_idle: got %b, required 0", rf_we); end
    endtask

    task automatic test_single_alu();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        push_exp(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b1) begin n_mis++; $display("FAIL single_ready: got %b, required 1", alu_ready); end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0) begin n_mis++; $display("FAIL single_early: got we=%b, required 0", rf_we); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin n_mis++; $display("FAIL single_write: got we=%b rd=%0d wd=%h, required 1/5/deadbeef", rf_we, rf_rd, rf_wd); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin n_mis++; $display("FAIL single_hold: got we=%b rd=%0d wd=%h, required 0/5/deadbeef", rf_we, rf_rd, rf_wd); end
    endtask

    task automatic test_contention();
        // First conflict after reset: LSU wins, pointer flips to ALU.
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA1A10003;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB2B20004;
        push_exp(5'd4, 32'hB2B20004);
        push_exp(5'd3, 32'hA1A10003);
        @(posedge clk); #1;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b0) begin n_mis++; $display("FAIL conf1_alu_wait: got ready=%b, required 0", alu_ready); end
        n_cmp++; if (lsu_ready !== 1'b1) begin n_mis++; $display("FAIL conf1_lsu_ready: got ready=%b, required 1", lsu_ready); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd4) begin n_mis++; $display("FAIL conf1_first: got we=%b rd=%0d, required 1/4", rf_we, rf_rd); end
        n_cmp++; if (alu_ready !== 1'b1) begin n_mis++; $display("FAIL conf1_alu_release: got ready=%b, required 1", alu_ready); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd3) begin n_mis++; $display("FAIL conf1_second: got we=%b rd=%0d, required 1/3", rf_we, rf_rd); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0) begin n_mis++; $display("FAIL conf1_idle: got we=%b, required 0", rf_we); end
        // Second conflict: ALU now has priority.
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA1A1000A;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB2B2000B;
        push_exp(5'd10, 32'hA1A1000A);
        push_exp(5'd11, 32'hB2B2000B);
        @(posedge clk); #1;
        alu_valid = 1'b0; lsu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin n_mis++; $display("FAIL conf2_ready: got alu=%b lsu=%b, required 1/0", alu_ready, lsu_ready); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd10) begin n_mis++; $display("FAIL conf2_first: got we=%b rd=%0d, required 1/10", rf_we, rf_rd); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd11) begin n_mis++; $display("FAIL conf2_second: got we=%b rd=%0d, required 1/11", rf_we, rf_rd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d;
        @(posedge clk); #1;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                d = $urandom;
                alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = d;
                push_exp(5'(i + 1), d);
                last_wd = d;
            end else begin
                alu_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                n_cmp++; if (alu_ready !== 1'b1) begin n_mis++; $display("FAIL stream_ready[%0d]: got %b, required 1", i, alu_ready); end
            end
            n_cmp++; if (rf_we !== (i >= 2 && i <= 9)) begin n_mis++; $display("FAIL stream_we[%0d]: got %b, required %b", i, rf_we, (i >= 2 && i <= 9)); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rd_zero();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
        @(posedge clk); #1;
        alu_rd = 5'd12; alu_data = 32'hC0DE000C;
        push_exp(5'd12, 32'hC0DE000C);
        @(negedge clk);
        n_cmp++; if (alu_ready !== 1'b1) begin n_mis++; $display("FAIL x0_ready: got %b, required 1", alu_ready); end
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0 || rf_rd !== 5'd8 || rf_wd !== last_wd) begin n_mis++; $display("FAIL x0_suppress: got we=%b rd=%0d wd=%h, required 0/8/%h", rf_we, rf_rd, rf_wd, last_wd); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd12) begin n_mis++; $display("FAIL x0_next: got we=%b rd=%0d, required 1/12", rf_we, rf_rd); end
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
`ifdef WB_SCOREBOARD_EN
        @(posedge clk); #1;
        sb_set = 1'b1; sb_rd = 5'd7;
        @(posedge clk); #1;
        sb_rd = 5'd0;
        @(negedge clk);
        n_cmp++; if (sb_busy !== 32'h00000080) begin n_mis++; $display("FAIL sb_set7: got %h, required 00000080", sb_busy); end
        @(posedge clk); #1;
        sb_set = 1'b0;
        @(negedge clk);
        n_cmp++; if (sb_busy !== 32'h00000080) begin n_mis++; $display("FAIL sb_set0: got %h, required 00000080", sb_busy); end
        // ALU write to a busy register leaves the bitmap alone.
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA7A7A7A7;
        push_exp(5'd7, 32'hA7A7A7A7);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || sb_busy !== 32'h00000080) begin n_mis++; $display("FAIL sb_alu: got we=%b busy=%h, required 1/00000080", rf_we, sb_busy); end
        // Load result clears the bit in the same cycle the write is presented.
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1D1D0007;
        push_exp(5'd7, 32'h1D1D0007);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b0 || sb_busy !== 32'h00000080) begin n_mis++; $display("FAIL sb_pre_clear: got we=%b busy=%h, required 0/00000080", rf_we, sb_busy); end
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || sb_busy !== 32'h0) begin n_mis++; $display("FAIL sb_clear: got we=%b rd=%0d busy=%h, required 1/7/0", rf_we, rf_rd, sb_busy); end
        // Re-mark rd7, then set it again on the clearing edge: set wins.
        @(posedge clk); #1;
        sb_set = 1'b1; sb_rd = 5'd7;
        @(posedge clk); #1;
        sb_set = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h2D2D0007;
        push_exp(5'd7, 32'h2D2D0007);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        sb_set = 1'b1; sb_rd = 5'd7; sb_clear_ok = 1'b1;
        @(negedge clk);
        n_cmp++; if (sb_busy !== 32'h00000080) begin n_mis++; $display("FAIL sb_busy_again: got %h, required 00000080", sb_busy); end
        @(posedge clk); #1;
        sb_set = 1'b0; sb_clear_ok = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_we !== 1'b1 || sb_busy !== 32'h00000080) begin n_mis++; $display("FAIL sb_set_wins: got we=%b busy=%h, required 1/00000080", rf_we, sb_busy); end
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h3D3D0007;
        push_exp(5'd7, 32'h3D3D0007);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (sb_busy !== 32'h0) begin n_mis++; $display("FAIL sb_final_clear: got %h, required 0", sb_busy); end
`else
        @(posedge clk); #1;
        sb_set = 1'b1; sb_rd = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1D1D0007;
        push_exp(5'd7, 32'h1D1D0007);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (sb_busy !== 32'h0) begin n_mis++; $display("FAIL sb_off[%0d]: got %h, required 0", i, sb_busy); end
            @(posedge clk); #1;
            sb_set = 1'b0;
        end
`endif
        n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL drain: got %0d pending writes, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA0A00014;
        lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'hB0B00015;
        sb_set = 1'b1; sb_rd = 5'd9;
        @(posedge clk); #1;
        alu_valid = 1'b0; lsu_valid = 1'b0; sb_set = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rf_we, rf_rd, rf_wd} !== '0) begin n_mis++; $display("FAIL midrst_wport: got we=%b rd=%0d wd=%h, required 0", rf_we, rf_rd, rf_wd); end
        n_cmp++; if (sb_busy !== '0) begin n_mis++; $display("FAIL midrst_sb: got %h, required 0", sb_busy); end
        exp_q.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (rf_we !== 1'b0 || alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin n_mis++; $display("FAIL midrst_idle[%0d]: got we=%b alu_rdy=%b lsu_rdy=%b, required 0/1/1", i, rf_we, alu_ready, lsu_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contention();
        test_back_to_back();
        test_rd_zero();
        test_scoreboard();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Register-file writeback unit. It is the write-side producer for the 32x32 register file: it drives the file's write enable, destination index and write data.
- Accepts results from the ALU (fixed latency) and the LSU (variable latency) over valid/ready handshakes.
- Buffers each source in a 1-entry skid, arbitrates round-robin on conflicts, and issues at most one register write per cycle.
- Keeps a pending-load scoreboard that decode uses to stall reads of registers not yet written.

Parameters:
- XLEN, 32, data width of results and write data.
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  XLEN  ALU result.
- alu_ready_o  out  1  ALU skid can accept.
- lsu_valid_i  in  1  load result valid.
- lsu_rd_i  in  5  load destination register.
- lsu_data_i  in  XLEN  load data.
- lsu_ready_o  out  1  LSU skid can accept.
- sb_set_i  in  1  load issued; mark sb_rd_i pending.
- sb_rd_i  in  5  destination of the issued load.
- sb_busy_o  out  NREGS  pending-load bitmap.
- rf_we_o  out  1  register file write enable.
- rf_rd_o  out  5  register file write index.
- rf_wd_o  out  XLEN  register file write data.

Behaviour:
- Reset (async, rst_ni low) clears:
  - both skids to empty;
  - rf_we_o=0, rf_rd_o=0, rf_wd_o=0;
  - sb_busy_o=0;
  - round-robin pointer to "LSU first".
  - alu_ready_o and lsu_ready_o read 1 from the first cycle after reset release.
- Handshake: a transfer occurs on a rising edge where valid_i && ready_o. Data and rd are captured into that source's skid. A producer must hold valid, rd and data stable until the transfer.
- ready_o = skid empty OR skid being granted in the current cycle. A source can therefore sustain 1 result per cycle when uncontended.
- Arbitration, each cycle, among non-empty skids:
  - one candidate: it is granted;
  - both: the pointer's source is granted and the pointer toggles to the other source.
  - The pointer changes only on a conflict, so no source waits more than 1 cycle per conflict.
- Write port is registered: a grant in cycle N gives rf_we_o=1 with rf_rd_o/rf_wd_o of the granted entry in cycle N+1.
  - The register file commits on the N+1 edge.
  - Minimum latency from input transfer to rf_we_o high is 2 edges (capture, grant).
  - rf_rd_o and rf_wd_o hold their last values when rf_we_o=0.
- rd == 0: the entry is granted and dequeued normally but rf_we_o stays 0. No x0 write is ever issued.
- Scoreboard:
  - Set: sb_set_i with sb_rd_i != 0 sets bit sb_rd_i on the next edge. Bit 0 is constant 0.
  - Clear: a granted LSU entry clears bit rd on the same edge as its write is registered, so bit low coincides with rf_we_o high.
  - Set and clear of the same index on the same edge: set wins.
  - Set of an already-set bit: bit stays 1. Decode must not issue a second load to a busy rd; the bench asserts this.
  - ALU grants never touch the scoreboard.
- Asynchronous reset mid-operation discards any buffered entries; no write is issued afterwards.

Optional Feature:
- Macro WB_SCOREBOARD_EN.
  - Defined: scoreboard logic exactly as described in Behaviour.
  - Undefined: no scoreboard flops; sb_busy_o is tied to 0 and sb_set_i/sb_rd_i are ignored. Decode must use another interlock.

Decomposition:
- Package wb_pkg holds:
  - XLEN and REG_AW = 5;
  - source enum {SRC_LSU, SRC_ALU};
  - a packed struct wb_entry_t {rd, data}.
- Sub-module wb_skid: 1-entry valid/ready buffer holding a wb_entry_t, with a grant input. It is instantiated once per source.

Test Plan:
- Reset release, ALU sends rd=5, data=0xDEADBEEF -> 2 edges later rf_we_o=1, rf_rd_o=5, rf_wd_o=0xDEADBEEF for exactly 1 cycle.
- ALU and LSU skids both full on the same cycle (ALU rd=3, LSU rd=4), pointer at LSU -> LSU written first, ALU next cycle. alu_ready_o=0 during the wait cycle. The pointer then favours ALU on the next conflict.
- Continuous ALU stream of 8 results with no LSU traffic -> 8 consecutive rf_we_o=1 cycles and alu_ready_o constantly 1.
- ALU sends rd=0, data=0x1234 -> handshake completes, rf_we_o stays 0.
- sb_set_i with rd=7 -> sb_busy_o[7]=1. A later LSU result for rd=7 -> bit 7 low in the same cycle rf_we_o=1. sb_set_i rd=7 on the clear edge -> bit stays 1. With WB_SCOREBOARD_EN undefined -> sb_busy_o=0 throughout.
- rst_ni asserted while both skids are full -> all outputs 0 immediately. After release, no write occurs without new input.
